mac_xgmii_tx_mapper: RTL and testbench

MAC_XGMII_TX_MAPPER -- requirements
Module: mac_xgmii_tx_mapper

---
 rtl/mac_pkg.sv | 32 +++
 rtl/xgmii_term_builder.sv | 24 ++
 rtl/mac_xgmii_tx_mapper.sv | 150 +++++++++++++++
 tb/tb_mac_xgmii_tx_mapper.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared XGMII control codes, frame constants and TX mapper state encoding.
package mac_pkg;

    localparam logic [7:0]  XGMII_IDLE   = 8'h07;
    localparam logic [7:0]  XGMII_START  = 8'hFB;
    localparam logic [7:0]  XGMII_TERM   = 8'hFD;
    localparam logic [7:0]  XGMII_ERROR  = 8'hFE;
    localparam logic [63:0] PREAMBLE_SFD = 64'hD555555555555555;
    localparam logic [63:0] IDLE_COL     = {8{XGMII_IDLE}};
    localparam logic [63:0] ERROR_COL    = {8{XGMII_ERROR}};

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StTerm,
        StIpg,
        StDrop
    } tx_state_e;

    // A last-word byte count of 0 or anything above 8 means a full word.
    function automatic logic [3:0] norm_last_bytes(logic [3:0] raw);
        return (raw == 4'd0 || raw > 4'd8) ? 4'd8 : raw;
    endfunction

    // Whole idle columns needed after the /T/ column; lanes above t_lane already carry idles.
    function automatic int unsigned ipg_cols(int unsigned min_ipg, int unsigned t_lane);
        int rem;
        rem = int'(min_ipg) - (7 - int'(t_lane));
        return (rem <= 0) ? 0 : (rem + 7) / 8;
    endfunction

endpackage

// File: rtl/xgmii_term_builder.sv
// Builds an XGMII column for the final word of a frame: n data lanes, /T/ in lane n, idles above.
module xgmii_term_builder
    import mac_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [3:0]  i_n,
    output logic [63:0] o_txd,
    output logic [7:0]  o_txc
);

    always_comb begin
        o_txd = IDLE_COL;
        o_txc = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < i_n) begin
                o_txd[8*k +: 8] = i_data[8*k +: 8];
                o_txc[k]        = 1'b0;
            end else if (4'(k) == i_n) begin
                o_txd[8*k +: 8] = XGMII_TERM;
            end
        end
    end

endmodule

// File: rtl/mac_xgmii_tx_mapper.sv
// Maps a 64-bit frame word stream (preamble first) onto XGMII TX columns with /S/, /T/,
// inter-packet gap enforcement and underflow error signalling.
module mac_xgmii_tx_mapper
    import mac_pkg::*;
#(
    parameter int unsigned MIN_IPG_BYTES = 12
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [63:0] i_data,
    input  logic        i_last,
    input  logic [3:0]  i_last_bytes,
    output logic        o_ready,
    output logic [63:0] o_txd,
    output logic [7:0]  o_txc,
    output logic        o_frame_done,
    output logic        o_err
);

    localparam int unsigned CntW     = 16;
    localparam int unsigned TermCols = ipg_cols(MIN_IPG_BYTES, 0);

    tx_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [63:0]       txd_q, txd_d;
    logic [7:0]        txc_q, txc_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic              ready;
    logic [3:0]        n_norm;
    logic [3:0]        term_n;
    logic [63:0]       term_txd;
    logic [7:0]        term_txc;
    logic              do_load;
    logic [CntW-1:0]   load_val;

    assign n_norm = norm_last_bytes(i_last_bytes);
    // The standalone terminate column is simply a zero-byte last word.
    assign term_n = (state_q == StTerm) ? 4'd0 : n_norm;

    xgmii_term_builder u_term_builder (
        .i_data (i_data),
        .i_n    (term_n),
        .o_txd  (term_txd),
        .o_txc  (term_txc)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        txd_d        = IDLE_COL;
        txc_d        = 8'hFF;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        ready        = 1'b0;
        do_load      = 1'b0;
        load_val     = '0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (i_valid) begin
                    if (i_last) begin
                        err_d = 1'b1;
                    end else begin
                        txd_d   = {i_data[63:8], XGMII_START};
                        txc_d   = 8'h01;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                ready = 1'b1;
                if (!i_valid) begin
                    txd_d   = ERROR_COL;
                    err_d   = 1'b1;
                    state_d = StDrop;
                end else if (!i_last) begin
                    txd_d = i_data;
                    txc_d = 8'h00;
                end else begin
                    txd_d = term_txd;
                    txc_d = term_txc;
                    if (n_norm == 4'd8) begin
                        state_d = StTerm;
                    end else begin
                        frame_done_d = 1'b1;
                        do_load      = 1'b1;
                        load_val     = CntW'(ipg_cols(MIN_IPG_BYTES, {28'd0, n_norm}));
                    end
                end
            end
            StTerm: begin
                txd_d        = term_txd;
                txc_d        = term_txc;
                frame_done_d = 1'b1;
                do_load      = 1'b1;
                load_val     = CntW'(TermCols);
            end
            StIpg: begin
                if (cnt_q <= CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDrop: begin
                ready = 1'b1;
                if (i_valid && i_last) begin
                    state_d = StIpg;
                    cnt_d   = CntW'(2);
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_load) begin
            cnt_d   = load_val;
            state_d = (load_val == '0) ? StIdle : StIpg;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            txd_q        <= IDLE_COL;
            txc_q        <= 8'hFF;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            txd_q        <= txd_d;
            txc_q        <= txc_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign o_ready      = ready & ~i_rst;
    assign o_txd        = txd_q;
    assign o_txc        = txc_q;
    assign o_frame_done = frame_done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_mac_xgmii_tx_mapper.sv
// Bench for mac_xgmii_tx_mapper: last-word vector table, corner sequences, and random
// back-to-back frames checked against a byte-stream model of the wire.
module tb_mac_xgmii_tx_mapper;

    localparam int unsigned MinIpg  = 12;
    localparam logic [63:0] Pre     = 64'hD555555555555555;
    localparam logic [63:0] IdleCol = 64'h0707070707070707;
    localparam logic [63:0] TermCol = 64'h07070707070707FD;
    localparam logic [63:0] SCol    = 64'hD5555555555555FB;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid, i_last;
    logic [63:0] i_data;
    logic [3:0]  i_last_bytes;
    logic        o_ready;
    logic [63:0] o_txd;
    logic [7:0]  o_txc;
    logic        o_frame_done, o_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_xgmii_tx_mapper #(.MIN_IPG_BYTES(MinIpg)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_last       (i_last),
        .i_last_bytes (i_last_bytes),
        .o_ready      (o_ready),
        .o_txd        (o_txd),
        .o_txc        (o_txc),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    typedef struct {
        logic [3:0]  nb;
        logic [63:0] data;
        logic [63:0] txd;
        logic [7:0]  txc;
        bit          term;
        int          gap;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_in();
        i_valid      = 1'b0;
        i_last       = 1'b0;
        i_last_bytes = 4'd0;
        i_data       = '0;
    endtask

    // Present a word, wait (bounded) for o_ready, transfer it; outputs then show its column.
    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int waited;
        waited       = 0;
        i_valid      = 1'b1;
        i_data       = d;
        i_last       = last;
        i_last_bytes = nb;
        while (!o_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!o_ready) check("ready wait", 64'(o_ready), 64'd1);
        tick();
        idle_in();
    endtask

    // Count idle columns until the mapper accepts again.
    task automatic gap_check(input string name, input int exp_gap);
        int gap;
        gap = 0;
        while (!o_ready && gap < 50) begin
            tick();
            gap++;
            check({name, " gap txd"}, o_txd, IdleCol);
            check({name, " gap txc"}, 64'(o_txc), 64'hFF);
        end
        check({name, " gap cols"}, 64'(gap), 64'(exp_gap));
    endtask

    // Wire-level model state
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    logic [7:0] got[$];
    bit         mon_en = 1'b0;
    bit         in_frame = 1'b0;
    int         gap_bytes = 1000;
    int         frames_seen = 0;
    int         fd_seen = 0;
    logic [7:0] mb;
    logic       mc;
    int         m_len, m_bad;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_frame_done) fd_seen++;
            for (int k = 0; k < 8; k++) begin
                mb = o_txd[8*k +: 8];
                mc = o_txc[k];
                if (!mc) begin
                    if (in_frame) got.push_back(mb);
                    else check("stray data lane", 64'(mc), 64'd1);
                end else if (mb == 8'hFB) begin
                    check("start lane", 64'(k), 64'd0);
                    check("ipg bytes >= min", 64'(gap_bytes >= int'(MinIpg)), 64'd1);
                    in_frame = 1'b1;
                    got.delete();
                end else if (mb == 8'hFD) begin
                    check("frame_done with /T/", 64'(o_frame_done), 64'd1);
                    if (exp_len.size() == 0) begin
                        check("frame expected", 64'(exp_len.size()), 64'd1);
                    end else begin
                        m_len = exp_len.pop_front();
                        m_bad = 0;
                        for (int i = 0; i < m_len; i++) begin
                            if (i >= got.size() || got[i] !== exp_bytes[0]) m_bad++;
                            void'(exp_bytes.pop_front());
                        end
                        check("frame length", 64'(got.size()), 64'(m_len));
                        check("frame bytes bad", 64'(m_bad), 64'd0);
                        frames_seen++;
                    end
                    in_frame  = 1'b0;
                    gap_bytes = 0;
                end else if (mb == 8'h07) begin
                    if (!in_frame) gap_bytes++;
                end else begin
                    check("unexpected control", 64'(mb), 64'h07);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int          drv_len, drv_n;
    logic [3:0]  drv_nb;
    logic [63:0] drv_d;
    bit          drv_last;

    initial begin
        vecs[0] = '{4'd4,  64'h1122334455667788, 64'h070707FD55667788, 8'hF0, 1'b0, 2};
        vecs[1] = '{4'd1,  64'h1122334455667788, 64'h070707070707FD88, 8'hFE, 1'b0, 1};
        vecs[2] = '{4'd7,  64'h1122334455667788, 64'hFD22334455667788, 8'h80, 1'b0, 2};
        vecs[3] = '{4'd8,  64'h1122334455667788, 64'h1122334455667788, 8'h00, 1'b1, 1};
        vecs[4] = '{4'd0,  64'hA5A55A5AC3C33C3C, 64'hA5A55A5AC3C33C3C, 8'h00, 1'b1, 1};
        vecs[5] = '{4'd12, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'h00, 1'b1, 1};
        vecs[6] = '{4'd2,  64'h0123456789ABCDEF, 64'h0707070707FDCDEF, 8'hFC, 1'b0, 1};
        vecs[7] = '{4'd5,  64'h0123456789ABCDEF, 64'h0707FD6789ABCDEF, 8'hE0, 1'b0, 2};
        vecs[8] = '{4'd3,  64'h0123456789ABCDEF, 64'h07070707FDABCDEF, 8'hF8, 1'b0, 1};

        // Reset state, with a word offered while reset is held
        idle_in();
        i_valid = 1'b1;
        i_rst   = 1'b1;
        repeat (3) tick();
        check("rst ready", 64'(o_ready), 64'd0);
        check("rst txd", o_txd, IdleCol);
        check("rst txc", 64'(o_txc), 64'hFF);
        check("rst frame_done", 64'(o_frame_done), 64'd0);
        check("rst err", 64'(o_err), 64'd0);
        idle_in();
        i_rst = 1'b0;
        #1;
        check("post-rst ready", 64'(o_ready), 64'd1);

        // Lone last word in IDLE is malformed
        tick();
        send(64'hDEADBEEFCAFEF00D, 1'b1, 4'd8);
        check("lone last err", 64'(o_err), 64'd1);
        check("lone last txd", o_txd, IdleCol);
        check("lone last txc", 64'(o_txc), 64'hFF);
        tick();
        check("lone last err clears", 64'(o_err), 64'd0);
        check("lone last txd after", o_txd, IdleCol);

        // Nine-word frame ending on a full word
        send(Pre, 1'b0, 4'd0);
        check("f9 S txd", o_txd, SCol);
        check("f9 S txc", 64'(o_txc), 64'h01);
        for (int i = 1; i < 9; i++) begin
            drv_d = {32'(i * 17), 32'(i * 1000 + 3)};
            send(drv_d, i == 8, 4'd8);
            check("f9 data txd", o_txd, drv_d);
            check("f9 data txc", 64'(o_txc), 64'h00);
        end
        check("f9 ready low in TERM", 64'(o_ready), 64'd0);
        check("f9 no early done", 64'(o_frame_done), 64'd0);
        tick();
        check("f9 T txd", o_txd, TermCol);
        check("f9 T txc", 64'(o_txc), 64'hFF);
        check("f9 T done", 64'(o_frame_done), 64'd1);
        gap_check("f9", 1);

        // Last-word table
        foreach (vecs[v]) begin
            send(Pre, 1'b0, 4'd0);
            check("vec S txd", o_txd, SCol);
            send(vecs[v].data, 1'b1, vecs[v].nb);
            check("vec last txd", o_txd, vecs[v].txd);
            check("vec last txc", 64'(o_txc), 64'(vecs[v].txc));
            if (vecs[v].term) begin
                check("vec full no done", 64'(o_frame_done), 64'd0);
                tick();
                check("vec T txd", o_txd, TermCol);
                check("vec T txc", 64'(o_txc), 64'hFF);
            end
            check("vec done", 64'(o_frame_done), 64'd1);
            gap_check("vec", vecs[v].gap);
        end

        // Underflow on the fourth word, remainder dropped
        send(Pre, 1'b0, 4'd0);
        send(64'h1111111111111111, 1'b0, 4'd0);
        send(64'h2222222222222222, 1'b0, 4'd0);
        tick();
        check("uf txd", o_txd, 64'hFEFEFEFEFEFEFEFE);
        check("uf txc", 64'(o_txc), 64'hFF);
        check("uf err", 64'(o_err), 64'd1);
        check("uf ready", 64'(o_ready), 64'd1);
        for (int i = 3; i < 9; i++) begin
            send({$urandom, $urandom}, i == 8, 4'd8);
            check("drop txd", o_txd, IdleCol);
            check("drop err", 64'(o_err), 64'd0);
            check("drop done", 64'(o_frame_done), 64'd0);
        end
        gap_check("drop", 2);
        send(Pre, 1'b0, 4'd0);
        check("after drop S txd", o_txd, SCol);
        send(64'h0102030405060708, 1'b1, 4'd3);
        check("after drop done", 64'(o_frame_done), 64'd1);
        gap_check("after drop", 1);

        // Reset in mid-frame
        send(Pre, 1'b0, 4'd0);
        send(64'h3333333333333333, 1'b0, 4'd0);
        send(64'h4444444444444444, 1'b0, 4'd0);
        i_rst = 1'b1;
        #1;
        check("midrst txd", o_txd, IdleCol);
        check("midrst txc", 64'(o_txc), 64'hFF);
        check("midrst ready", 64'(o_ready), 64'd0);
        tick();
        i_rst = 1'b0;
        #1;
        check("midrst release ready", 64'(o_ready), 64'd1);
        tick();
        check("midrst idle col", o_txd, IdleCol);
        check("midrst no done", 64'(o_frame_done), 64'd0);
        check("midrst no err", 64'(o_err), 64'd0);
        send(Pre, 1'b0, 4'd0);
        check("midrst S txd", o_txd, SCol);
        check("midrst S txc", 64'(o_txc), 64'h01);
        send(64'h5555666677778888, 1'b1, 4'd6);
        check("midrst done", 64'(o_frame_done), 64'd1);
        gap_check("midrst", 2);

        // Random frames, mostly back to back, checked on the wire byte stream
        mon_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            drv_len = int'($urandom_range(10, 2));
            drv_nb  = 4'($urandom_range(15, 0));
            drv_n   = (drv_nb == 4'd0 || drv_nb > 4'd8) ? 8 : int'(drv_nb);
            exp_len.push_back(7 + 8 * (drv_len - 2) + drv_n);
            for (int w = 0; w < drv_len; w++) begin
                drv_d    = (w == 0) ? Pre : {$urandom, $urandom};
                drv_last = (w == drv_len - 1);
                for (int b = (w == 0) ? 1 : 0; b < (drv_last ? drv_n : 8); b++)
                    exp_bytes.push_back(drv_d[8*b +: 8]);
                send(drv_d, drv_last, drv_nb);
            end
            if (f % 3 == 2) repeat ($urandom_range(3, 0)) tick();
        end
        idle_in();
        repeat (20) tick();
        mon_en = 1'b0;
        check("rand frames pending", 64'(exp_len.size()), 64'd0);
        check("rand frames seen", 64'(frames_seen), 64'd30);
        check("rand frame_done count", 64'(fd_seen), 64'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
